// File: rtl/rom_read_arbiter_if.sv
// Requester, ROM and read-stream signals of the ROM read arbiter.
// slave = arbiter side, master = requesters/ROM/consumer side.
interface rom_read_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REQ    = 4,
  parameter int LEN_WIDTH  = 7,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [ADDR_WIDTH-1:0]         rom_address;
  logic                          rom_enable;
  logic [DATA_WIDTH-1:0]         rom_data;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          rd_valid;
  logic [ID_WIDTH-1:0]           rd_id;
  logic                          rd_last;
  logic                          rd_ready;

  modport slave (
    input  req_valid, req_addr, req_len, rom_data, rd_ready,
    output req_ready, rom_address, rom_enable, rd_data, rd_valid, rd_id, rd_last
  );

  modport master (
    output req_valid, req_addr, req_len, rom_data, rd_ready,
    input  req_ready, rom_address, rom_enable, rd_data, rd_valid, rd_id, rd_last
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin burst arbiter in front of a 1-cycle registered single-port ROM.
// The ROM output register is the only output stage; rd_valid tracks its contents.
module rom_read_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REQ    = 4,
  parameter int LEN_WIDTH  = 7,
  parameter int ID_WIDTH   = 2
) (
  input logic               clk,
  input logic               reset,
  rom_read_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_q, rr_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;

  logic                  found;
  logic [ID_WIDTH-1:0]   win, cand;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [LEN_WIDTH-1:0]  win_len;
  logic [NUM_REQ-1:0]    grant;
  logic                  rd_fire, issue;

  // First valid requester at or after the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(rr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    grant    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_WIDTH'(i)) begin
        win_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
        grant[i] = found && (state_q == S_IDLE) && !reset;
      end
    end
  end

  assign rd_fire = rd_valid_q & bus.rd_ready;
  // A new read may only overwrite the ROM register once its word is gone.
  assign issue   = !reset && (state_q == S_BURST) && (rem_q != '0) && (!rd_valid_q || rd_fire);

  assign bus.req_ready   = grant;
  assign bus.rom_enable  = issue;
  assign bus.rom_address = addr_q;
  assign bus.rd_data     = DATA_WIDTH'(bus.rom_data);
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_last     = rd_last_q;
  assign bus.rd_id       = owner_q;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    case (state_q)
      S_IDLE: begin
        if (|grant) begin
          addr_d  = win_addr;
          rem_d   = win_len;
          owner_d = win;
          rr_d    = ID_WIDTH'((int'(win) + 1) % NUM_REQ);
          if (win_len != '0) state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rd_fire && rd_last_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      rd_valid_d = 1'b1;
      rd_last_d  = (rem_q == LEN_WIDTH'(1));
    end else if (rd_fire) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      owner_q    <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed scenarios plus random traffic, all
// checked against a burst-level scoreboard and round-robin model.
module tb_rom_read_arbiter;
  localparam int DW = 16, AW = 6, NR = 4, LW = 7, IW = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rom_read_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR),
                        .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus();

  rom_read_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR),
                     .LEN_WIDTH(LW), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // ROM model: registered read, output holds while enable is low.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rom_q;
  always @(posedge clk) if (bus.rom_enable) rom_q <= mem[bus.rom_address];
  assign bus.rom_data = rom_q;

  logic [AW-1:0] ra [NR];
  logic [LW-1:0] rl [NR];
  for (genvar gi = 0; gi < NR; gi++) begin : g_pack
    assign bus.req_addr[gi*AW +: AW] = ra[gi];
    assign bus.req_len[gi*LW +: LW]  = rl[gi];
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] id;
    logic          last;
  } word_t;

  word_t exp_q[$];
  int gnt_log[$];
  int gnt_cyc[$];
  int addr_log[$];
  int checks = 0, errors = 0;
  int cyc = 0, last_fire_cyc = 0, grant_cyc = 0, pending = 0, issue_left = 0, rr = 0, fire_cnt = 0;
  logic [AW-1:0] iss_addr = '0;
  logic [DW-1:0] prev_data = '0;
  logic [NR-1:0] granted = '0;
  bit first_pending = 0, prev_stall = 0, prev_stream = 0, post_rst = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] rv;
    word_t w;
    int win, len, a, ci;
    cyc++;
    granted = bus.req_ready & bus.req_valid;
    if (reset) begin
      exp_q.delete();
      pending = 0; issue_left = 0; rr = 0; first_pending = 0;
      prev_stall = 0; prev_stream = 0; last_fire_cyc = cyc; post_rst = 1;
      return;
    end
    if (post_rst) begin
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rom_enable", bus.rom_enable, 0);
      chk("rst_rd_last", bus.rd_last, 0);
      chk("rst_rd_id", bus.rd_id, 0);
      chk("rst_rom_address", bus.rom_address, 0);
      post_rst = 0;
    end
    if (bus.rom_enable) begin
      chk("rom_issue_expected", issue_left > 0, 1);
      chk("rom_address", bus.rom_address, iss_addr);
      addr_log.push_back(int'(bus.rom_address));
      iss_addr = iss_addr + 1'b1;
      if (issue_left > 0) issue_left--;
    end
    if (prev_stall) begin
      chk("hold_valid", bus.rd_valid, 1);
      chk("hold_data", bus.rd_data, prev_data);
    end
    if (prev_stream) chk("stream_valid", bus.rd_valid, 1);
    prev_stall = 0;
    prev_stream = 0;
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", bus.rd_valid, 0);
      else begin
        w = exp_q[0];
        if (first_pending) begin
          chk("first_latency", cyc, grant_cyc + 2);
          first_pending = 0;
        end
        chk("rd_data", bus.rd_data, w.d);
        chk("rd_id", bus.rd_id, w.id);
        chk("rd_last", bus.rd_last, w.last);
        if (!bus.rd_ready) begin
          chk("stall_enable", bus.rom_enable, 0);
          prev_stall = 1;
          prev_data = bus.rd_data;
        end else begin
          void'(exp_q.pop_front());
          fire_cnt++;
          pending--;
          if (pending == 0) last_fire_cyc = cyc;
          else prev_stream = 1;
        end
      end
    end
    // Arbitration: only when no burst is outstanding and not in the fire cycle.
    exp_rdy = '0;
    win = 0;
    rv = bus.req_valid;
    if (pending == 0 && cyc > last_fire_cyc) begin
      for (int k = 0; k < NR; k++) begin
        ci = (rr + k) % NR;
        if (exp_rdy == '0 && rv[IW'(ci)]) begin
          exp_rdy[IW'(ci)] = 1'b1;
          win = ci;
        end
      end
    end
    chk("req_ready", bus.req_ready, exp_rdy);
    if (exp_rdy != '0) begin
      len = int'(rl[IW'(win)]);
      a = int'(ra[IW'(win)]);
      rr = (win + 1) % NR;
      gnt_log.push_back(win);
      gnt_cyc.push_back(cyc);
      for (int j = 0; j < len; j++) begin
        w.d = mem[AW'(a + j)];
        w.id = IW'(win);
        w.last = (j == len - 1);
        exp_q.push_back(w);
      end
      pending = len;
      issue_left = len;
      iss_addr = AW'(a);
      if (len > 0) begin
        grant_cyc = cyc;
        first_pending = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~granted;
  endtask

  task automatic set_req(input int i, input int addr, input int len);
    ra[IW'(i)] = AW'(addr);
    rl[IW'(i)] = LW'(len);
    bus.req_valid[IW'(i)] = 1'b1;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.req_valid != '0 || cyc <= last_fire_cyc) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_within_budget", n < budget, 1);
  endtask

  initial begin
    int n, f0, rr_exp[5], wrap_exp[4];
    rr_exp = '{0, 1, 2, 3, 0};
    wrap_exp = '{62, 63, 0, 1};
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'((($urandom() % 1024) << AW) | i);
    for (int i = 0; i < NR; i++) begin ra[i] = '0; rl[i] = '0; end
    bus.req_valid = '0;
    bus.rd_ready = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Round-robin with all requesters held high.
    gnt_log.delete();
    for (int i = 0; i < NR; i++) set_req(i, i * 3, 1);
    n = 0;
    while (gnt_log.size() < 5 && n < 100) begin tick(); bus.req_valid = '1; n++; end
    bus.req_valid = '0;
    chk("rr_grant_count", gnt_log.size(), 5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) chk("rr_order", gnt_log[i], rr_exp[i]);
    run_idle(100);

    // Single burst.
    f0 = fire_cnt;
    set_req(0, 5, 3);
    run_idle(100);
    chk("single_words", fire_cnt - f0, 3);

    // Backpressure after the first word.
    f0 = fire_cnt;
    set_req(1, 10, 4);
    n = 0;
    while (fire_cnt == f0 && n < 50) begin tick(); n++; end
    bus.rd_ready = 1'b0;
    repeat (3) tick();
    bus.rd_ready = 1'b1;
    run_idle(100);
    chk("bp_words", fire_cnt - f0, 4);

    // Address wrap.
    addr_log.delete();
    set_req(3, 62, 4);
    run_idle(100);
    chk("wrap_count", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("wrap_addr", addr_log[i], wrap_exp[i]);

    // Zero-length burst followed immediately by another grant.
    gnt_log.delete(); gnt_cyc.delete();
    f0 = fire_cnt;
    set_req(2, 7, 0);
    tick();
    set_req(1, 30, 2);
    tick();
    run_idle(100);
    chk("zero_grants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("zero_first_id", gnt_log[0], 2);
      chk("zero_next_id", gnt_log[1], 1);
      chk("zero_next_gap", gnt_cyc[1] - gnt_cyc[0], 1);
    end
    chk("zero_words", fire_cnt - f0, 2);

    // Reset during the second word of a long burst.
    f0 = fire_cnt;
    set_req(0, 20, 8);
    n = 0;
    while (fire_cnt == f0 && n < 50) begin tick(); n++; end
    reset = 1'b1;
    set_req(0, 40, 2);
    set_req(3, 50, 2);
    gnt_log.delete();
    tick();
    reset = 1'b0;
    run_idle(200);
    chk("rst_grant_count", gnt_log.size(), 2);
    if (gnt_log.size() > 0) chk("rst_first_grant", gnt_log[0], 0);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      bus.rd_ready = ($urandom() % 4) != 0;
      for (int i = 0; i < NR; i++)
        if (!bus.req_valid[IW'(i)] && ($urandom() % 6) == 0)
          set_req(i, int'($urandom() % DEPTH),
                  (($urandom() % 8) == 0) ? int'($urandom() % 128) : int'($urandom() % 6));
      tick();
    end
    bus.rd_ready = 1'b1;
    run_idle(3000);
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
